// File: rtl/ck_riscv_pkg.sv
// Shared core constants for the writeback arbiter: register address/data widths and the x0 index.
package ck_riscv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned AGE_CNT_W  = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;
  typedef logic [AGE_CNT_W-1:0]  age_cnt_t;

  localparam reg_addr_t X0_IDX  = '0;
  localparam age_cnt_t  AGE_MAX = '1;

  function automatic logic is_x0(input reg_addr_t addr);
    return addr == X0_IDX;
  endfunction

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Bundle of the two writeback request channels, the pipeline hold, the register-file write port and debug state.
interface regfile_wb_arb_if;

  // Handshake: a request transfers on a rising edge where vld and rdy are both high.
  // The requester holds vld/addr/data stable until then; rdy is combinational and may
  // depend on vld, but vld must never depend on rdy.
  logic                    wb_stall;
  logic                    alu_wb_vld;
  logic                    alu_wb_rdy;
  ck_riscv_pkg::reg_addr_t alu_wb_addr;
  ck_riscv_pkg::xdata_t    alu_wb_data;
  logic                    lsu_wb_vld;
  logic                    lsu_wb_rdy;
  ck_riscv_pkg::reg_addr_t lsu_wb_addr;
  ck_riscv_pkg::xdata_t    lsu_wb_data;
  logic                    wr_reg_en;
  ck_riscv_pkg::reg_addr_t wr_reg_addr;
  ck_riscv_pkg::xdata_t    wr_wdata;
  ck_riscv_pkg::age_cnt_t  age_cnt;

  modport master (
    output wb_stall,
    output alu_wb_vld, alu_wb_addr, alu_wb_data,
    output lsu_wb_vld, lsu_wb_addr, lsu_wb_data,
    input  alu_wb_rdy, lsu_wb_rdy,
    input  wr_reg_en, wr_reg_addr, wr_wdata, age_cnt
  );

  modport slave (
    input  wb_stall,
    input  alu_wb_vld, alu_wb_addr, alu_wb_data,
    input  lsu_wb_vld, lsu_wb_addr, lsu_wb_data,
    output alu_wb_rdy, lsu_wb_rdy,
    output wr_reg_en, wr_reg_addr, wr_wdata, age_cnt
  );

endinterface

// File: rtl/regfile_wb_arb.sv
// Two-source register-file writeback arbiter (LSU over ALU) with a registered write port.
// Optional ALU anti-starvation ageing is enabled by defining RF_WB_AGE_EN.
module regfile_wb_arb
  import ck_riscv_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_wb_arb_if.slave  wb
);

`ifdef RF_WB_AGE_EN
  localparam bit AgeEn = 1'b1;
`else
  localparam bit AgeEn = 1'b0;
`endif
  localparam age_cnt_t AgeLimitC = age_cnt_t'(AGE_LIMIT);

  logic      live_q, live_d;
  age_cnt_t  age_cnt_q, age_cnt_d;
  logic      wr_en_q, wr_en_d;
  reg_addr_t wr_addr_q, wr_addr_d;
  xdata_t    wr_data_q, wr_data_d;

  logic      alu_force;
  logic      alu_rdy;
  logic      lsu_rdy;
  logic      acc;
  reg_addr_t acc_addr;
  xdata_t    acc_data;

  // live_q is cleared asynchronously and rises on the first edge after release,
  // so both rdy stay low for the whole reset without routing rst_n into data logic.
  always_comb begin
    live_d    = 1'b1;
    alu_force = AgeEn && (age_cnt_q >= AgeLimitC);
    alu_rdy   = live_q && !wb.wb_stall && wb.alu_wb_vld && (!wb.lsu_wb_vld || alu_force);
    lsu_rdy   = live_q && !wb.wb_stall && wb.lsu_wb_vld && !(wb.alu_wb_vld && alu_force);
    acc       = alu_rdy || lsu_rdy;
    acc_addr  = lsu_rdy ? wb.lsu_wb_addr : wb.alu_wb_addr;
    acc_data  = lsu_rdy ? wb.lsu_wb_data : wb.alu_wb_data;

    age_cnt_d = age_cnt_q;
`ifdef RF_WB_AGE_EN
    if (!wb.alu_wb_vld || alu_rdy) begin
      age_cnt_d = '0;
    end else if (!wb.wb_stall && (age_cnt_q != AGE_MAX)) begin
      age_cnt_d = age_cnt_q + age_cnt_t'(1);
    end
`else
    age_cnt_d = '0;
`endif

    // x0 requests complete the handshake but never reach the write port.
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (acc && !is_x0(acc_addr)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = acc_addr;
      wr_data_d = acc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      age_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      live_q    <= live_d;
      age_cnt_q <= age_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wb.alu_wb_rdy  = alu_rdy;
  assign wb.lsu_wb_rdy  = lsu_rdy;
  assign wb.wr_reg_en   = wr_en_q;
  assign wb.wr_reg_addr = wr_addr_q;
  assign wb.wr_wdata    = wr_data_q;
  assign wb.age_cnt     = age_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: expected writes are queued at issue time and a
// negedge monitor pops and compares them against the register-file write port.
module tb_regfile_wb_arb;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   lsu_idx;
  logic [36:0] exp_q[$];

  regfile_wb_arb_if bus();

  regfile_wb_arb #(.AGE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_wb_vld  = 1'b1;
    bus.alu_wb_addr = a;
    bus.alu_wb_data = d;
  endtask

  task automatic drive_lsu(input logic [4:0] a, input logic [31:0] d);
    bus.lsu_wb_vld  = 1'b1;
    bus.lsu_wb_addr = a;
    bus.lsu_wb_data = d;
  endtask

  task automatic idle_all();
    bus.alu_wb_vld = 1'b0;
    bus.lsu_wb_vld = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [36:0] e;
    if (bus.wr_reg_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h want no write",
                 bus.wr_reg_addr, bus.wr_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_reg_addr), 32'(e[36:32]));
        chk("wr_data", bus.wr_wdata, e[31:0]);
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.wb_stall = 1'b0;
    drive_alu(5'd1, 32'h0000_0001);
    drive_lsu(5'd2, 32'h0000_0002);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.wr_reg_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_reg_addr), 32'd0);
    chk("rst_wr_data", bus.wr_wdata, 32'd0);
    chk("rst_age", 32'(bus.age_cnt), 32'd0);
    chk("rst_alu_rdy", 32'(bus.alu_wb_rdy), 32'd0);
    chk("rst_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd0);
    idle_all();
    rst_n = 1'b1;
    step();

    // ALU only
    drive_alu(5'd5, 32'h1234_5678);
    #1;
    chk("t1_alu_rdy", 32'(bus.alu_wb_rdy), 32'd1);
    chk("t1_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd0);
    push(5'd5, 32'h1234_5678);
    step();
    idle_all();
    step();
    #1;
    chk("t1_en_low", 32'(bus.wr_reg_en), 32'd0);
    chk("t1_addr_hold", 32'(bus.wr_reg_addr), 32'd5);

    // collision: LSU first, ALU next cycle
    drive_alu(5'd3, 32'h3333_3333);
    drive_lsu(5'd7, 32'hDEAD_BEEF);
    #1;
    chk("t2_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd1);
    chk("t2_alu_rdy0", 32'(bus.alu_wb_rdy), 32'd0);
    push(5'd7, 32'hDEAD_BEEF);
    step();
    bus.lsu_wb_vld = 1'b0;
    #1;
    chk("t2_alu_rdy1", 32'(bus.alu_wb_rdy), 32'd1);
    push(5'd3, 32'h3333_3333);
    step();
    idle_all();
    step();

    // x0 filter
    drive_lsu(5'd0, 32'hFFFF_FFFF);
    #1;
    chk("t3_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd1);
    step();
    idle_all();
    #1;
    chk("t3_x0_en", 32'(bus.wr_reg_en), 32'd0);
    chk("t3_addr_hold", 32'(bus.wr_reg_addr), 32'd3);

    // back-to-back LSU
    for (int i = 0; i < 3; i++) begin
      drive_lsu(5'(10 + i), 32'hA000_0000 + 32'(i));
      #1;
      chk("t4_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd1);
      push(5'(10 + i), 32'hA000_0000 + 32'(i));
      step();
    end
    idle_all();
    step();

    // starvation
    lsu_idx = 0;
    drive_alu(5'd4, 32'h0000_0AAA);
    drive_lsu(5'd20, 32'hB000_0000);
`ifdef RF_WB_AGE_EN
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c < 4) begin
        chk("t5_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd1);
        chk("t5_alu_rdy0", 32'(bus.alu_wb_rdy), 32'd0);
        push(5'(20 + lsu_idx), 32'hB000_0000 + 32'(lsu_idx));
        step();
        #1;
        chk("t5_age", 32'(bus.age_cnt), 32'(c + 1));
        lsu_idx++;
        drive_lsu(5'(20 + lsu_idx), 32'hB000_0000 + 32'(lsu_idx));
      end else begin
        chk("t5_alu_rdy1", 32'(bus.alu_wb_rdy), 32'd1);
        chk("t5_lsu_rdy0", 32'(bus.lsu_wb_rdy), 32'd0);
        push(5'd4, 32'h0000_0AAA);
        step();
        #1;
        chk("t5_age_clr", 32'(bus.age_cnt), 32'd0);
        bus.alu_wb_vld = 1'b0;
      end
    end
    #1;
    chk("t5_lsu_after", 32'(bus.lsu_wb_rdy), 32'd1);
    push(5'(20 + lsu_idx), 32'hB000_0000 + 32'(lsu_idx));
    step();
    idle_all();
    step();
`else
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t5_alu_starved", 32'(bus.alu_wb_rdy), 32'd0);
      chk("t5_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd1);
      chk("t5_age_tied", 32'(bus.age_cnt), 32'd0);
      push(5'(20 + lsu_idx), 32'hB000_0000 + 32'(lsu_idx));
      step();
      lsu_idx++;
      drive_lsu(5'(20 + lsu_idx), 32'hB000_0000 + 32'(lsu_idx));
    end
    bus.lsu_wb_vld = 1'b0;
    #1;
    chk("t5_alu_rdy1", 32'(bus.alu_wb_rdy), 32'd1);
    push(5'd4, 32'h0000_0AAA);
    step();
    idle_all();
    step();
`endif

    // stall right after an acceptance
    drive_lsu(5'd13, 32'h1313_1313);
    #1;
    chk("t6_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd1);
    push(5'd13, 32'h1313_1313);
    step();
    bus.wb_stall = 1'b1;
    drive_alu(5'd14, 32'h1414_1414);
    drive_lsu(5'd15, 32'h1515_1515);
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t6_stall_alu_rdy", 32'(bus.alu_wb_rdy), 32'd0);
      chk("t6_stall_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd0);
      chk("t6_stall_age", 32'(bus.age_cnt), 32'd0);
      if (s > 0) chk("t6_stall_en", 32'(bus.wr_reg_en), 32'd0);
      step();
    end
    bus.wb_stall = 1'b0;
    #1;
    chk("t6_rel_lsu_rdy", 32'(bus.lsu_wb_rdy), 32'd1);
    push(5'd15, 32'h1515_1515);
    step();
    bus.lsu_wb_vld = 1'b0;
    #1;
    chk("t6_rel_alu_rdy", 32'(bus.alu_wb_rdy), 32'd1);
    push(5'd14, 32'h1414_1414);
    step();
    idle_all();
    step();

    // reset in the acceptance cycle of x9
    drive_alu(5'd9, 32'h9999_9999);
    #1;
    chk("t7_alu_rdy", 32'(bus.alu_wb_rdy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_en", 32'(bus.wr_reg_en), 32'd0);
    chk("t7_rst_addr", 32'(bus.wr_reg_addr), 32'd0);
    chk("t7_rst_data", bus.wr_wdata, 32'd0);
    chk("t7_rst_rdy", 32'(bus.alu_wb_rdy), 32'd0);
    @(negedge clk);
    idle_all();
    step();
    rst_n = 1'b1;
    step();
    step();
    #1;
    chk("t7_no_x9", 32'(bus.wr_reg_en), 32'd0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter AGE_LIMIT, default 4: consecutive ALU-stalled cycles before the ALU is force-granted (range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port wb_stall, input, 1: pipeline hold, no acceptance while high.
REQ-005 SHALL have ports alu_wb_vld (in, 1), alu_wb_rdy (out, 1), alu_wb_addr (in, 5), alu_wb_data (in, 32): ALU writeback request channel.
REQ-006 SHALL have ports lsu_wb_vld (in, 1), lsu_wb_rdy (out, 1), lsu_wb_addr (in, 5), lsu_wb_data (in, 32): load-result writeback request channel.
REQ-007 SHALL have ports wr_reg_en (out, 1), wr_reg_addr (out, 5), wr_wdata (out, 32): registered drive of the register-file write port.
REQ-008 SHALL have port age_cnt (out, 4): current ALU starvation count, debug only.

Function
REQ-009 SHALL transfer a request only in a cycle where its vld and rdy are both high; requesters hold vld/addr/data stable until accepted.
REQ-010 SHALL drive alu_wb_rdy and lsu_wb_rdy combinationally, at most one high per cycle, both low while wb_stall=1.
REQ-011 SHALL by default grant LSU over ALU when both vld are high.
REQ-012 SHALL present an accepted request on wr_reg_en/wr_reg_addr/wr_wdata exactly one cycle after acceptance, for exactly one cycle.
REQ-013 SHALL drive wr_reg_en=0 in any cycle following a cycle with no acceptance; wr_reg_addr/wr_wdata hold their last value.
REQ-014 SHALL accept requests with addr=0 (rdy asserted normally) but SHALL NOT assert wr_reg_en for them; x0 stays zero.
REQ-015 SHALL allow back-to-back acceptance every cycle (full throughput, no bubble between grants).
REQ-016 SHALL, with wb_stall=1 in the cycle after an acceptance, still write that accepted request (stall blocks acceptance, not the output stage).

Reset
REQ-017 SHALL on rst_n low asynchronously clear wr_reg_en, wr_reg_addr, wr_wdata and age_cnt to 0.
REQ-018 SHALL hold both rdy low while rst_n is low; a request presented during reset is not accepted and must be re-held after release.
REQ-019 SHALL discard a request accepted in the cycle reset asserts (no write after reset release).

Configuration
REQ-020 SHALL implement ALU anti-starvation only when macro RF_WB_AGE_EN is defined.
REQ-021 With RF_WB_AGE_EN: age_cnt increments (saturating at 15) each cycle alu_wb_vld=1 and alu_wb_rdy=0 and wb_stall=0; clears on ALU acceptance or alu_wb_vld=0; when age_cnt>=AGE_LIMIT the ALU is granted over LSU.
REQ-022 Without RF_WB_AGE_EN: pure fixed LSU>ALU priority, age_cnt tied to 0, ALU may starve indefinitely.

Structure
REQ-023 SHALL take register-address width (5), data width (32) and the x0 index constant from the shared core package ck_riscv_pkg.
REQ-024 SHALL be a single module with no sub-modules; the grant decision and output stage are in-line logic.

Verification
REQ-025 ALU only: alu vld, addr=5, data=0x1234_5678 -> alu_rdy same cycle; next cycle wr_reg_en=1, addr=5, wdata=0x1234_5678; following cycle wr_reg_en=0.
REQ-026 Collision: both vld, alu addr=3, lsu addr=7 data=0xDEAD_BEEF -> lsu accepted first (write x7), alu accepted next cycle (write x3 one cycle later).
REQ-027 x0 filter: lsu vld addr=0 data=0xFFFF_FFFF -> lsu_rdy=1, next cycle wr_reg_en=0.
REQ-028 Starvation (RF_WB_AGE_EN, AGE_LIMIT=4): alu vld held, lsu vld every cycle -> age_cnt 1,2,3,4, then alu_rdy=1 on the fifth contention cycle, age_cnt back to 0; without macro alu never granted.
REQ-029 Stall: wb_stall=1 for 3 cycles with both vld -> both rdy low, no writes; a request accepted just before stall is still written.
REQ-030 Reset mid-operation: assert rst_n=0 in the acceptance cycle of addr=9 -> all outputs 0 immediately, no write of x9 after release.
